sub_serial_seq: RTL and testbench
=================================

# sub_serial_seq

Multi-byte unsigned subtraction sequencer. Computes A − B on NBYTES-wide operands by driving a single 8-bit subtract-with-borrow slice once per cycle, least-significant byte first, chaining the borrow between bytes. It lets the subtractor datapath handle wide operands without replicating hardware. Upstream and downstream connect through valid/ready handshakes.

## Interface

Parameters:
- NBYTES, default 4: operand width in bytes; legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept an operand pair.
- a  input  8*NBYTES  unsigned minuend.
- b  input  8*NBYTES  unsigned subtrahend.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- diff  output  8*NBYTES  (A − B) mod 2^(8*NBYTES).
- borrow  output  1  1 iff A < B, i.e. the final borrow-out.
- zero  output  1  1 iff diff == 0.
- busy  output  1  high in RUN or DONE.

Reset: one clock. rst_n is asynchronous and active-low.

## Operation

- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready: register a and b, clear the byte index and borrow-in, clear diff, then go to RUN.
- **RUN**, once per cycle for byte i:
  - {bout, d} = a[i] − b[i] − bin, computed 9 bits wide.
  - diff byte i ← d.
  - bin ← bout.
  - i increments by 1.
  - After processing byte NBYTES−1, go to DONE with borrow ← final bout.
- **DONE**
  - out_valid = 1.
  - diff, borrow and zero are held stable until out_ready is sampled high, then go to IDLE.
- in_ready is 0 in RUN and DONE. A new operand pair is never accepted in the same cycle a result is consumed.
- zero is computed combinationally from the registered diff and is only meaningful while out_valid = 1.
- Arithmetic rules:
  - Each byte is unsigned.
  - Borrow-in to byte 0 is 0.
  - diff wraps modulo 2^(8*NBYTES).
  - borrow equals (A < B) on the full-width values.
- Operands are captured at acceptance. Changes on a or b after the handshake have no effect.
- Reset values: state IDLE; in_ready 1 once rst_n is released; out_valid 0; diff 0; borrow 0; zero 1; busy 0; byte index 0; borrow-in 0.
- Reset mid-operation: the operation is discarded and all outputs return to their reset values immediately (asynchronously). No partial result is ever presented.

## Timing

- Handshake at rising edge T, where in_valid && in_ready is sampled.
- Bytes 0..NBYTES−1 are written at edges T+1..T+NBYTES.
- out_valid rises after edge T+NBYTES. Latency from acceptance to result is NBYTES+1 cycles.
- The result remains valid for as long as out_ready stays low (unbounded backpressure).
- If out_ready is sampled high at edge R, then out_valid = 0 and in_ready = 1 after R. The next acceptance can happen no earlier than edge R+1.
- Throughput: one operation per NBYTES+2 cycles with out_ready held high.
- in_valid held across a busy period: the request is accepted only in IDLE. Upstream must hold a and b stable while in_valid = 1 and in_ready = 0.

## Structure

- Shared package sub_pkg:
  - state enum {IDLE, RUN, DONE}.
  - constant BYTE_W = 8.
  - function for the index width, $clog2(NBYTES).
- Sub-module sub_byte_borrow: combinational, inputs a[7:0], b[7:0], bin; outputs d[7:0], bout. It is instantiated once and is the only arithmetic in the block.
- The top level holds the FSM, byte index counter, operand registers, diff register and borrow register. Operand bytes are selected by index through a mux; the registers are not shifted.

## Test plan

All scenarios use NBYTES = 4.
- **Basic subtraction:** a=0x00000005, b=0x00000003 → diff=0x00000002, borrow=0, zero=0; out_valid rises exactly 5 cycles after acceptance.
- **Underflow wrap:** a=0x00000000, b=0x00000001 → diff=0xFFFFFFFF, borrow=1, zero=0.
- **Multi-byte borrow chain:** a=0x00010000, b=0x000000FF → diff=0x0000FF01, borrow=0.
- **Equal operands:** a=b=0xDEADBEEF → diff=0x00000000, borrow=0, zero=1.
- **Backpressure and busy-time changes:**
  - Hold out_ready=0 for 10 cycles: out_valid stays 1, outputs do not change.
  - Drive in_valid=1 with different operands throughout: they are not accepted, in_ready=0.
  - Release out_ready: the next operation is accepted one cycle later.
- **Reset mid-run:**
  - Deassert rst_n after byte 1 of a=0xFFFFFFFF, b=0x1: out_valid=0, diff=0, busy=0 immediately.
  - After reset release, a=0x10, b=0x20 → diff=0xFFFFFFF0, borrow=1.

Source files
------------

// File: rtl/sub_pkg.sv
// Shared definitions for the serial multi-byte subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  // Width of a byte index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_byte_borrow.sv
// One 8-bit subtract-with-borrow slice, shared by every byte of the operation.
module sub_byte_borrow
  import sub_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              bin,
  output logic [BYTE_W-1:0] d,
  output logic              bout
);

  logic [BYTE_W:0] w_res;

  // A ninth bit captures the borrow: it is set whenever a < b + bin.
  assign w_res = {1'b0, a} - {1'b0, b} - {{BYTE_W{1'b0}}, bin};
  assign d     = w_res[BYTE_W-1:0];
  assign bout  = w_res[BYTE_W];

endmodule

// File: rtl/sub_serial_seq.sv
// Serial A-B sequencer: one byte per cycle, LSB first, borrow chained between bytes.
module sub_serial_seq
  import sub_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] diff,
  output logic                     borrow,
  output logic                     zero,
  output logic                     busy
);

  localparam int              W    = BYTE_W * NBYTES;
  localparam int              IW   = idx_w(NBYTES);
  localparam logic [IW-1:0]   LAST = IW'(NBYTES - 1);

  state_t             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_diff;
  logic [IW-1:0]      r_idx;
  logic               r_bin;
  logic               r_borrow;

  logic [BYTE_W-1:0]  w_a_byte;
  logic [BYTE_W-1:0]  w_b_byte;
  logic [BYTE_W-1:0]  w_d;
  logic               w_bout;

  // Operand bytes are picked by index; the operand registers never shift.
  assign w_a_byte = r_a[r_idx*BYTE_W +: BYTE_W];
  assign w_b_byte = r_b[r_idx*BYTE_W +: BYTE_W];

  sub_byte_borrow u_slice (
    .a    (w_a_byte),
    .b    (w_b_byte),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
      r_bin    <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_diff   <= '0;
            r_idx    <= '0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_diff[r_idx*BYTE_W +: BYTE_W] <= w_d;
          r_bin <= w_bout;
          r_idx <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_borrow <= w_bout;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign zero      = (r_diff == '0);

endmodule

// File: tb/tb_sub_serial_seq.sv
// Directed bench for sub_serial_seq with NBYTES = 4.
module tb_sub_serial_seq;

  localparam int NB = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   a         = '0;
  logic [31:0]   b         = '0;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   diff;
  logic          borrow;
  logic          zero;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub_serial_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .zero      (zero),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge while in_ready is high; returns at the
  // falling edge after the accepting rising edge, with operands scrambled.
  task automatic start_op(input logic [31:0] va, input logic [31:0] vb);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = ~va;
    b        = ~vb;
  endtask

  // Latency counted in cycles including the acceptance cycle.
  task automatic wait_done(output int lat);
    int e;
    e = 0;
    while (!out_valid && e < 20) begin
      @(negedge clk);
      e++;
    end
    lat = e + 1;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val("consume_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("consume_in_ready",  {31'b0, in_ready},  32'd1);
  endtask

  task automatic run_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ed, input logic eb, input logic ez);
    int lat;
    start_op(va, vb);
    wait_done(lat);
    check_val({name, "_latency"}, lat, 32'd5);
    check_val({name, "_diff"},   diff, ed);
    check_val({name, "_borrow"}, {31'b0, borrow}, {31'b0, eb});
    check_val({name, "_zero"},   {31'b0, zero},   {31'b0, ez});
    $display("op %s: a=0x%08h b=0x%08h diff=0x%08h borrow=%0b zero=%0b lat=%0d",
             name, va, vb, diff, borrow, zero, lat);
    consume();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    // Reset state while rst_n is low
    #1;
    check_val("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("rst_diff",      diff,               32'd0);
    check_val("rst_borrow",    {31'b0, borrow},    32'd0);
    check_val("rst_zero",      {31'b0, zero},      32'd1);
    check_val("rst_busy",      {31'b0, busy},      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", {31'b0, in_ready}, 32'd1);

    run_op("basic",     32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0);
    run_op("underflow", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("chain",     32'h0001_0000, 32'h0000_00FF, 32'h0000_FF01, 1'b0, 1'b0);
    run_op("equal",     32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b1);

    // Backpressure with a competing request held on the input
    start_op(32'h0000_0100, 32'h0000_0001);
    wait_done(lat);
    check_val("bp_latency", lat, 32'd5);
    a        = 32'h1234_5678;
    b        = 32'h1111_1111;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check_val("bp_diff",      diff,               32'h0000_00FF);
      check_val("bp_borrow",    {31'b0, borrow},    32'd0);
      check_val("bp_in_ready",  {31'b0, in_ready},  32'd0);
    end
    $display("op backpressure: diff=0x%08h held 10 cycles", diff);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("bp_release_in_ready",  {31'b0, in_ready},  32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("bp_next_busy",     {31'b0, busy},     32'd1);
    check_val("bp_next_in_ready", {31'b0, in_ready}, 32'd0);
    wait_done(lat);
    check_val("bp_next_latency", lat, 32'd5);
    check_val("bp_next_diff",    diff, 32'h0123_4567);
    check_val("bp_next_borrow",  {31'b0, borrow}, 32'd0);
    $display("op pending: a=0x12345678 b=0x11111111 diff=0x%08h borrow=%0b", diff, borrow);
    consume();

    // Reset after byte 1 has been written
    start_op(32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    @(negedge clk);
    check_val("mid_partial_diff", diff, 32'h0000_FFFE);
    check_val("mid_busy",         {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_val("mid_rst_diff",      diff,               32'd0);
    check_val("mid_rst_busy",      {31'b0, busy},      32'd0);
    check_val("mid_rst_zero",      {31'b0, zero},      32'd1);
    check_val("mid_rst_borrow",    {31'b0, borrow},    32'd0);
    $display("op reset_mid_run: diff=0x%08h busy=%0b", diff, busy);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    run_op("post_rst", 32'h0000_0010, 32'h0000_0020, 32'hFFFF_FFF0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
